// File: rtl/io_handshake_responder_pkg.sv
// rtl/io_handshake_responder_pkg.sv - shared FSM encodings and default fill byte
package io_handshake_responder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam logic [7:0] DEFAULT_FILL = 8'h00;

endpackage

// File: rtl/io_handshake_responder_fifo.sv
// rtl/io_handshake_responder_fifo.sv - circular-buffer FIFO with first-word-fall-through head
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4,
  localparam int AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(depth);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Storage is deliberately left out of reset; only pointers and occupancy clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/io_handshake_responder.sv
// rtl/io_handshake_responder.sv - 4-phase handshake responder exchanging one byte per transaction
module io_handshake_responder
  import io_handshake_responder_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter int         AW    = 2,
  parameter logic [7:0] FILL  = DEFAULT_FILL
) (
  input  logic          g_clk,
  input  logic          g_clr,
  input  logic          proc_hs_out,
  input  logic [7:0]    proc_bus_out,
  output logic          proc_hs_in,
  output logic [7:0]    proc_bus_in,
  input  logic          tx_wr_en,
  input  logic [7:0]    tx_wr_data,
  output logic          tx_full,
  output logic [AW:0]   tx_count,
  input  logic          rx_rd_en,
  output logic [7:0]    rx_rd_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_count,
  output logic          tx_underrun
);

  logic [0:0] state_q, state_d;
  logic       hs_in_q, hs_in_d;
  logic [7:0] bus_in_q, bus_in_d;
  logic       underrun_q, underrun_d;
  logic       tx_pop, tx_empty, rx_push, rx_full;
  logic [7:0] tx_head;

  sync_fifo #(.width(8), .depth(DEPTH)) TX_FIFO (
    .clk(g_clk), .clr_n(g_clr),
    .push(tx_wr_en), .push_data(tx_wr_data),
    .pop(tx_pop), .pop_data(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.width(8), .depth(DEPTH)) RX_FIFO (
    .clk(g_clk), .clr_n(g_clr),
    .push(rx_push), .push_data(proc_bus_out),
    .pop(rx_rd_en), .pop_data(rx_rd_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    state_d    = state_q;
    hs_in_d    = hs_in_q;
    bus_in_d   = bus_in_q;
    underrun_d = 1'b0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // RX fullness is the registered value, so a same-edge host pop does not unblock a full RX.
        if (proc_hs_out && !rx_full) begin
          rx_push = 1'b1;
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            bus_in_d = tx_head;
          end else begin
            bus_in_d   = FILL;
            underrun_d = 1'b1;
          end
          hs_in_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!proc_hs_out) begin
          hs_in_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q    <= ST_IDLE;
      hs_in_q    <= 1'b0;
      bus_in_q   <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_in_q    <= hs_in_d;
      bus_in_q   <= bus_in_d;
      underrun_q <= underrun_d;
    end
  end

  assign proc_hs_in  = hs_in_q;
  assign proc_bus_in = bus_in_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_io_handshake_responder.sv
// tb/tb_io_handshake_responder.sv - randomized self-checking bench against a queue-based transaction model
module tb_io_handshake_responder;

  localparam logic [7:0] FILL_B = 8'hFF;

  logic       g_clk = 1'b0;
  logic       g_clr;
  logic       proc_hs_out;
  logic [7:0] proc_bus_out;
  logic       proc_hs_in;
  logic [7:0] proc_bus_in;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_full;
  logic [2:0] tx_count;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_empty;
  logic [2:0] rx_count;
  logic       tx_underrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  io_handshake_responder #(.DEPTH(4), .AW(2), .FILL(FILL_B)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .proc_hs_out(proc_hs_out), .proc_bus_out(proc_bus_out),
    .proc_hs_in(proc_hs_in), .proc_bus_in(proc_bus_in),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .tx_full(tx_full), .tx_count(tx_count),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
    .rx_empty(rx_empty), .rx_count(rx_count),
    .tx_underrun(tx_underrun)
  );

  always #5 g_clk = ~g_clk;

  task automatic step();
    @(negedge g_clk);
  endtask

  task automatic apply_reset();
    g_clr = 1'b0; proc_hs_out = 1'b0; proc_bus_out = 8'h00;
    tx_wr_en = 1'b0; tx_wr_data = 8'h00; rx_rd_en = 1'b0;
    step(); step();
    g_clr = 1'b1;
    tx_q.delete(); rx_q.delete();
  endtask

  task automatic host_push(input logic [7:0] b);
    tx_wr_en = 1'b1; tx_wr_data = b;
    step();
    tx_wr_en = 1'b0;
    if (tx_q.size() < 4) tx_q.push_back(b);
  endtask

  // One processor transaction: the byte returned is the TX head, or FILL when TX is empty.
  function automatic logic [7:0] model_txn(input logic [7:0] b, output logic uf);
    logic [7:0] r;
    if (tx_q.size() > 0) begin r = tx_q.pop_front(); uf = 1'b0; end
    else begin r = FILL_B; uf = 1'b1; end
    rx_q.push_back(b);
    return r;
  endfunction

  task automatic do_txn(input logic [7:0] b, output logic [7:0] got, output logic uf,
                        output int lat, output logic dropped);
    proc_hs_out = 1'b1; proc_bus_out = b; lat = 0;
    do begin step(); lat++; end while (!proc_hs_in && lat < 20);
    got = proc_bus_in; uf = tx_underrun;
    proc_hs_out = 1'b0; proc_bus_out = 8'($urandom);
    step();
    dropped = !proc_hs_in;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (proc_hs_in !== 1'b0 || proc_bus_in !== 8'h00 || tx_underrun !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: hs_in=%b bus_in=%h underrun=%b required 0/00/0", proc_hs_in, proc_bus_in, tx_underrun); end
    tests++; if (tx_count !== 3'd0 || rx_count !== 3'd0 || tx_full !== 1'b0 || rx_empty !== 1'b1) begin
      fails++; $display("FAIL reset_fifos: tx_count=%0d rx_count=%0d tx_full=%b rx_empty=%b required 0/0/0/1", tx_count, rx_count, tx_full, rx_empty); end
    host_push(8'h5A);
    host_push(8'h6B);
    proc_hs_out = 1'b1; proc_bus_out = 8'h77;
    step();
    tests++; if (proc_hs_in !== 1'b1 || proc_bus_in !== 8'h5A) begin
      fails++; $display("FAIL reset_pre_ack: hs_in=%b bus_in=%h required 1/5a", proc_hs_in, proc_bus_in); end
    #2 g_clr = 1'b0;
    #1;
    tests++; if (proc_hs_in !== 1'b0 || proc_bus_in !== 8'h00 || tx_count !== 3'd0 || rx_empty !== 1'b1 || rx_count !== 3'd0) begin
      fails++; $display("FAIL reset_mid_ack: hs_in=%b bus_in=%h tx_count=%0d rx_empty=%b rx_count=%0d required 0/00/0/1/0",
                        proc_hs_in, proc_bus_in, tx_count, rx_empty, rx_count); end
    proc_hs_out = 1'b0;
    step();
    g_clr = 1'b1;
    tx_q.delete(); rx_q.delete();
  endtask

  task automatic test_exchange();
    logic [7:0] got; logic uf; int lat; logic dropped;
    apply_reset();
    host_push(8'hA5);
    do_txn(8'h3C, got, uf, lat, dropped);
    tests++; if (lat != 1 || got !== 8'hA5 || uf !== 1'b0) begin
      fails++; $display("FAIL exchange_ack: latency=%0d bus_in=%h underrun=%b required 1/a5/0", lat, got, uf); end
    tests++; if (!dropped) begin
      fails++; $display("FAIL exchange_drop: hs_in=%b required 0", proc_hs_in); end
    tests++; if (rx_rd_data !== 8'h3C || rx_count !== 3'd1 || tx_count !== 3'd0 || proc_bus_in !== 8'hA5) begin
      fails++; $display("FAIL exchange_state: rx_rd_data=%h rx_count=%0d tx_count=%0d bus_in=%h required 3c/1/0/a5",
                        rx_rd_data, rx_count, tx_count, proc_bus_in); end
  endtask

  task automatic test_underrun();
    logic [7:0] b;
    apply_reset();
    b = 8'($urandom);
    proc_hs_out = 1'b1; proc_bus_out = b;
    step();
    tests++; if (proc_hs_in !== 1'b1 || proc_bus_in !== FILL_B || tx_underrun !== 1'b1) begin
      fails++; $display("FAIL underrun_ack: hs_in=%b bus_in=%h underrun=%b required 1/ff/1", proc_hs_in, proc_bus_in, tx_underrun); end
    step();
    tests++; if (tx_underrun !== 1'b0 || proc_hs_in !== 1'b1) begin
      fails++; $display("FAIL underrun_pulse: underrun=%b hs_in=%b required 0/1", tx_underrun, proc_hs_in); end
    proc_hs_out = 1'b0;
    step();
    tests++; if (rx_rd_data !== b || rx_count !== 3'd1 || tx_underrun !== 1'b0) begin
      fails++; $display("FAIL underrun_rx: rx_rd_data=%h rx_count=%0d underrun=%b required %h/1/0", rx_rd_data, rx_count, tx_underrun, b); end
  endtask

  task automatic test_rx_full_stall();
    logic [7:0] got, exp, b; logic uf, euf; int lat; logic dropped;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) host_push(8'($urandom));
      b = 8'($urandom);
      exp = model_txn(b, euf);
      do_txn(b, got, uf, lat, dropped);
      tests++; if (got !== exp || uf !== euf || lat != 1 || !dropped) begin
        fails++; $display("FAIL stall_fill_%0d: bus_in=%h underrun=%b latency=%0d required %h/%b/1", i, got, uf, lat, exp, euf); end
    end
    b = 8'($urandom);
    proc_hs_out = 1'b1; proc_bus_out = b;
    repeat (3) step();
    tests++; if (proc_hs_in !== 1'b0 || rx_count !== 3'd4) begin
      fails++; $display("FAIL stall_hold: hs_in=%b rx_count=%0d required 0/4", proc_hs_in, rx_count); end
    tests++; if (rx_rd_data !== rx_q[0]) begin
      fails++; $display("FAIL stall_head: rx_rd_data=%h required %h", rx_rd_data, rx_q[0]); end
    rx_rd_en = 1'b1;
    step();
    rx_rd_en = 1'b0;
    void'(rx_q.pop_front());
    tests++; if (proc_hs_in !== 1'b0 || rx_count !== 3'd3) begin
      fails++; $display("FAIL stall_pop_edge: hs_in=%b rx_count=%0d required 0/3", proc_hs_in, rx_count); end
    exp = model_txn(b, euf);
    step();
    tests++; if (proc_hs_in !== 1'b1 || rx_count !== 3'd4 || proc_bus_in !== exp) begin
      fails++; $display("FAIL stall_release: hs_in=%b rx_count=%0d bus_in=%h required 1/4/%h", proc_hs_in, rx_count, proc_bus_in, exp); end
    proc_hs_out = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      tests++; if (rx_rd_data !== rx_q[0] || rx_empty !== 1'b0) begin
        fails++; $display("FAIL stall_drain_%0d: rx_rd_data=%h rx_empty=%b required %h/0", i, rx_rd_data, rx_empty, rx_q[0]); end
      rx_rd_en = 1'b1; step(); rx_rd_en = 1'b0;
      void'(rx_q.pop_front());
    end
    tests++; if (rx_empty !== 1'b1 || rx_count !== 3'd0) begin
      fails++; $display("FAIL stall_empty: rx_empty=%b rx_count=%0d required 1/0", rx_empty, rx_count); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, exp, b; logic uf, euf; int lat; logic dropped;
    apply_reset();
    host_push(8'($urandom));
    host_push(8'($urandom));
    b = 8'($urandom);
    proc_hs_out = 1'b1; proc_bus_out = b;
    tx_wr_en = 1'b1; tx_wr_data = 8'h11;
    exp = model_txn(b, euf);
    tx_q.push_back(8'h11);
    step();
    tx_wr_en = 1'b0;
    tests++; if (proc_hs_in !== 1'b1 || proc_bus_in !== exp || tx_count !== 3'd2) begin
      fails++; $display("FAIL simul_edge: hs_in=%b bus_in=%h tx_count=%0d required 1/%h/2", proc_hs_in, proc_bus_in, tx_count, exp); end
    proc_hs_out = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      host_push(8'($urandom));
      b = 8'($urandom);
      exp = model_txn(b, euf);
      do_txn(b, got, uf, lat, dropped);
      tests++; if (got !== exp || uf !== euf || lat != 1 || !dropped) begin
        fails++; $display("FAIL wrap_txn_%0d: bus_in=%h underrun=%b latency=%0d required %h/%b/1", i, got, uf, lat, exp, euf); end
      tests++; if (rx_rd_data !== rx_q[0] || tx_count !== 3'(tx_q.size())) begin
        fails++; $display("FAIL wrap_fifo_%0d: rx_rd_data=%h tx_count=%0d required %h/%0d", i, rx_rd_data, tx_count, rx_q[0], tx_q.size()); end
      rx_rd_en = 1'b1; step(); rx_rd_en = 1'b0;
      void'(rx_q.pop_front());
    end
  endtask

  task automatic test_held_request();
    logic [7:0] b, exp; logic euf; int bad; int rx_before;
    apply_reset();
    host_push(8'($urandom));
    host_push(8'($urandom));
    rx_before = rx_q.size();
    b = 8'($urandom);
    exp = model_txn(b, euf);
    proc_hs_out = 1'b1; proc_bus_out = b;
    step();
    tests++; if (proc_hs_in !== 1'b1 || proc_bus_in !== exp) begin
      fails++; $display("FAIL held_ack: hs_in=%b bus_in=%h required 1/%h", proc_hs_in, proc_bus_in, exp); end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      proc_bus_out = 8'($urandom);
      step();
      if (proc_hs_in !== 1'b1 || proc_bus_in !== exp || tx_underrun !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin
      fails++; $display("FAIL held_stable: %0d unstable cycles required 0", bad); end
    tests++; if (tx_count !== 3'(tx_q.size()) || rx_count !== 3'(rx_before + 1) || rx_rd_data !== b) begin
      fails++; $display("FAIL held_once: tx_count=%0d rx_count=%0d rx_rd_data=%h required %0d/%0d/%h",
                        tx_count, rx_count, rx_rd_data, tx_q.size(), rx_before + 1, b); end
    proc_hs_out = 1'b0;
    step();
    tests++; if (proc_hs_in !== 1'b0 || proc_bus_in !== exp) begin
      fails++; $display("FAIL held_release: hs_in=%b bus_in=%h required 0/%h", proc_hs_in, proc_bus_in, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp, b; logic uf, euf; int lat; logic dropped;
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          host_push(8'($urandom));
          tests++; if (tx_count !== 3'(tx_q.size()) || tx_full !== (tx_q.size() == 4)) begin
            fails++; $display("FAIL b2b_push_%0d: tx_count=%0d tx_full=%b required %0d/%b", it, tx_count, tx_full, tx_q.size(), tx_q.size() == 4); end
        end
        1: begin
          if (rx_q.size() > 0) begin
            tests++; if (rx_rd_data !== rx_q[0]) begin
              fails++; $display("FAIL b2b_head_%0d: rx_rd_data=%h required %h", it, rx_rd_data, rx_q[0]); end
            void'(rx_q.pop_front());
          end
          rx_rd_en = 1'b1; step(); rx_rd_en = 1'b0;
          tests++; if (rx_count !== 3'(rx_q.size()) || rx_empty !== (rx_q.size() == 0)) begin
            fails++; $display("FAIL b2b_pop_%0d: rx_count=%0d rx_empty=%b required %0d/%b", it, rx_count, rx_empty, rx_q.size(), rx_q.size() == 0); end
        end
        default: begin
          if (rx_q.size() < 4) begin
            b = 8'($urandom);
            exp = model_txn(b, euf);
            do_txn(b, got, uf, lat, dropped);
            tests++; if (got !== exp || uf !== euf || lat != 1 || !dropped) begin
              fails++; $display("FAIL b2b_txn_%0d: bus_in=%h underrun=%b latency=%0d dropped=%b required %h/%b/1/1",
                                it, got, uf, lat, dropped, exp, euf); end
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_exchange();
    test_underrun();
    test_rx_full_stall();
    test_simultaneous();
    test_held_request();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
